// File: rtl/truth_table_scanner_if.sv
// ============================================================================
// truth_table_scanner_if : scan handshake, function-under-test and result bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_scanner_if #(
   parameter int N = 3
) ();
   logic                start;
   logic                s;
   logic [N-1:0]        x;
   logic                busy;
   logic                done;
   logic [(1<<N)-1:0]   minterms;
   logic [(1<<N)-1:0]   maxterms;
   logic [N:0]          count;
   logic                xerr;

   modport master (
      output start, s,
      input  x, busy, done, minterms, maxterms, count, xerr
   );

   modport slave (
      input  start, s,
      output x, busy, done, minterms, maxterms, count, xerr
   );
endinterface

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// truth_table_scanner : walks every input combination of a boolean block and
// rebuilds its minterm/maxterm masks and minterm count. Optional: SCAN_XCHECK_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_scanner #(
   parameter int N      = 3,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_scanner_if.slave  bus
);
   localparam int         TT            = 1 << N;
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_SETTLE     = 2'd1;
   localparam logic [1:0] ST_SAMPLE     = 2'd2;
   localparam logic [1:0] ST_DONE       = 2'd3;
   localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE);
   localparam logic [1:0] ST_AFTER_LOAD = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [N-1:0] X_LAST      = '1;

   logic [1:0]    r_state;
   logic [3:0]    r_settle_cnt;
   logic [N-1:0]  r_x;
   logic [TT-1:0] r_minterms;
   logic [N:0]    r_count;
   logic          r_xerr;
   logic          w_s_unknown;
   logic          w_s_bit;

   // Unknown samples are recorded as 0 and flagged only when the check is built in.
   always_comb begin
      w_s_unknown = 1'b0;
`ifdef SCAN_XCHECK_EN
      w_s_unknown = (bus.s !== 1'b0) && (bus.s !== 1'b1);
`endif
      w_s_bit = w_s_unknown ? 1'b0 : bus.s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 4'd0;
         r_x          <= '0;
         r_minterms   <= '0;
         r_count      <= '0;
         r_xerr       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_x          <= '0;
                  r_minterms   <= '0;
                  r_count      <= '0;
                  r_xerr       <= 1'b0;
                  r_settle_cnt <= SETTLE_LOAD;
                  r_state      <= ST_AFTER_LOAD;
               end
            end
            ST_SETTLE: begin
               r_settle_cnt <= r_settle_cnt - 4'd1;
               if (r_settle_cnt <= 4'd1) begin
                  r_state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               r_minterms[r_x] <= w_s_bit;
               r_count         <= r_count + {{N{1'b0}}, w_s_bit};
               if (w_s_unknown) begin
                  r_xerr <= 1'b1;
               end
               if (r_x == X_LAST) begin
                  r_state <= ST_DONE;
               end else begin
                  r_x          <= r_x + 1'b1;
                  r_settle_cnt <= SETTLE_LOAD;
                  r_state      <= ST_AFTER_LOAD;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.x        = r_x;
   assign bus.busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign bus.done     = (r_state == ST_DONE);
   assign bus.minterms = r_minterms;
   assign bus.maxterms = ~r_minterms;
   assign bus.count    = r_count;
   assign bus.xerr     = r_xerr;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
// ============================================================================
// tb_truth_table_scanner : directed scans on an N=3/SETTLE=1 and an N=2/SETTLE=0 instance
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_scanner;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   fn_a = 0;

   always #5 clk = ~clk;

   truth_table_scanner_if #(.N(3)) bus_a ();
   truth_table_scanner_if #(.N(2)) bus_b ();

   truth_table_scanner #(.N(3), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   truth_table_scanner #(.N(2), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   // Functions under test, indexed by fn_a: 0 = y, 1 = 0, 2 = 1, 3 = unknown at index 3.
   always_comb begin
      case (fn_a)
         0:       bus_a.s = bus_a.x[1];
         1:       bus_a.s = 1'b0;
         2:       bus_a.s = 1'b1;
         default: bus_a.s = (bus_a.x == 3'd3) ? 1'bx : 1'b0;
      endcase
   end

   always_comb bus_b.s = bus_b.x[1] & ~bus_b.x[0];

   typedef struct {
      logic [63:0] mt;
      int          cnt;
      bit          chk_res;
      logic        xe;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_a(input int fsel);
      exp_t e;
      bit   b;
      e.mt = '0; e.cnt = 0; e.chk_res = 1'b1; e.xe = 1'b0;
      for (int i = 0; i < 8; i++) begin
         case (fsel)
            0:       b = i[1];
            1:       b = 1'b0;
            2:       b = 1'b1;
            default: b = 1'b0;
         endcase
         e.mt[i] = b;
         e.cnt   = e.cnt + int'(b);
      end
      if (fsel == 3) begin
`ifdef SCAN_XCHECK_EN
         e.xe = 1'b1;
`else
         e.chk_res = 1'b0;
`endif
      end
      return e;
   endfunction

   function automatic exp_t model_b();
      exp_t e;
      e.mt = '0; e.cnt = 0; e.chk_res = 1'b1; e.xe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e.mt[i] = i[1] & ~i[0];
         e.cnt   = e.cnt + int'(i[1] & ~i[0]);
      end
      return e;
   endfunction

   task automatic chk_reset_a();
      chk("rst_x",        bus_a.x,        64'h0);
      chk("rst_busy",     bus_a.busy,     64'h0);
      chk("rst_done",     bus_a.done,     64'h0);
      chk("rst_minterms", bus_a.minterms, 64'h0);
      chk("rst_maxterms", bus_a.maxterms, 64'hFF);
      chk("rst_count",    bus_a.count,    64'h0);
      chk("rst_xerr",     bus_a.xerr,     64'h0);
   endtask

   task automatic scan_a(input int fsel, input int pulse_at, input int abort_at);
      exp_t       e;
      bit         seen;
      int         k;
      logic [7:0] mx;
      fn_a = fsel;
      if (abort_at == 0) q_a.push_back(model_a(fsel));
      @(negedge clk); bus_a.start = 1'b1;
      @(negedge clk); bus_a.start = 1'b0;
      seen = 1'b0;
      k    = 1;
      while (!seen && k <= 40) begin
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_a();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         bus_a.start = (k == pulse_at);
         if (bus_a.done) begin
            seen = 1'b1;
            chk("a_done_cycle", k, 17);
            chk("a_busy_at_done", bus_a.busy, 64'h0);
            e  = q_a.pop_front();
            mx = ~e.mt[7:0];
            chk("a_xerr", bus_a.xerr, e.xe);
            if (e.chk_res) begin
               chk("a_minterms", bus_a.minterms, e.mt);
               chk("a_maxterms", bus_a.maxterms, mx);
               chk("a_count",    bus_a.count,    e.cnt);
            end
         end else if (k <= 16) begin
            chk("a_x_walk", bus_a.x, (k - 1) / 2);
            chk("a_busy",   bus_a.busy, 64'h1);
         end
         @(negedge clk);
         k++;
      end
      bus_a.start = 1'b0;
      chk("a_done_seen", seen, 1);
      if (seen) begin
         chk("a_done_pulse", bus_a.done, 64'h0);
         chk("a_x_hold",     bus_a.x,    64'h7);
         if (e.chk_res) chk("a_minterms_hold", bus_a.minterms, e.mt);
      end
   endtask

   task automatic scan_b();
      exp_t       e;
      bit         seen;
      int         k;
      logic [3:0] mx;
      q_b.push_back(model_b());
      @(negedge clk); bus_b.start = 1'b1;
      @(negedge clk); bus_b.start = 1'b0;
      seen = 1'b0;
      k    = 1;
      while (!seen && k <= 20) begin
         if (bus_b.done) begin
            seen = 1'b1;
            chk("b_done_cycle", k, 5);
            e  = q_b.pop_front();
            mx = ~e.mt[3:0];
            chk("b_minterms", bus_b.minterms, e.mt);
            chk("b_maxterms", bus_b.maxterms, mx);
            chk("b_count",    bus_b.count,    e.cnt);
            chk("b_xerr",     bus_b.xerr,     e.xe);
         end else if (k <= 4) begin
            chk("b_x_walk", bus_b.x,    k - 1);
            chk("b_busy",   bus_b.busy, 64'h1);
         end
         @(negedge clk);
         k++;
      end
      chk("b_done_seen", seen, 1);
   endtask

   initial begin
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      rst_n       = 1'b0;
      #12;
      chk_reset_a();
      @(negedge clk);
      rst_n = 1'b1;
      scan_a(0, 0, 0);   // f = y
      scan_a(1, 0, 0);   // constant 0
      scan_a(2, 0, 0);   // constant 1, count MSB set
      scan_a(0, 5, 0);   // start re-pulsed mid-scan
      scan_a(2, 0, 9);   // reset at cycle 9
      scan_a(1, 0, 0);   // fresh scan after reset
      scan_b();
      scan_a(3, 0, 0);   // unknown sample at index 3
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
